// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR sample sequencer.
// Optional WAIT timeout is enabled by defining FIR_SEQ_TIMEOUT_EN.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Width of a FIR result for a given sample width.
    function automatic int out_w(input int width);
        return 2 * width + 6;
    endfunction

endpackage

// File: rtl/fir_seq_fifo.sv
// Synchronous FIFO buffering upstream samples ahead of the FIR core.
// No pass-through: a push while full is refused even if a pop happens that cycle.
module fir_seq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Issues buffered samples to the FIR core one at a time and holds each result on a
// valid/ready port. Define FIR_SEQ_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.
module fir_sample_sequencer
    import fir_seq_pkg::*;
#(
    parameter int  WIDTH   = 16,
    parameter int  DEPTH   = 4,
    parameter int  TIMEOUT = 272,
    localparam int OUT_W   = out_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] FIR_input,
    output logic             input_valid,
    input  logic [OUT_W-1:0] FIR_output,
    input  logic             output_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic [15:0]      sample_count,
    output logic             err
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             pop;
    logic             capture;
    logic             ov_q;
    logic             ov_rise;
    logic             timeout_hit;

    fir_seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .pop     (pop),
        .data_in (s_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign s_ready = !fifo_full;
    assign busy    = (state != IDLE) || !fifo_empty;
    assign ov_rise = output_valid && !ov_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        input_valid = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !m_valid) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                input_valid = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (ov_rise) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ov_q         <= 1'b0;
            FIR_input    <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            sample_count <= '0;
        end else begin
            state <= state_next;
            ov_q  <= output_valid;
            if (pop) FIR_input <= fifo_head;
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (capture) begin
                m_data       <= FIR_output;
                m_valid      <= 1'b1;
                sample_count <= sample_count + 1'b1;
            end
        end
    end

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // wait_cnt holds the number of completed WAIT cycles; the abort lands on the last one.
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != WAIT) wait_cnt <= '0;
            else               wait_cnt <= wait_cnt + 1'b1;
            if (state == WAIT && !ov_rise && timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
